// File: rtl/fft_frame_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_packer_pkg
// Description : Shared FFT front-end definitions. Holds the sample and word
//               geometry, the lane field offset helper and the idle word that
//               both the frame packer and the downstream demux drive when no
//               valid data is present.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_frame_packer_pkg;

    localparam int SAMPLE_W        = 17;
    localparam int LANES           = 4;
    localparam int WORD_W          = 136;
    localparam int WORDS_PER_FRAME = 4;
    localparam int LANE_BITS       = 2 * SAMPLE_W;

    localparam logic [WORD_W-1:0] IDLE_WORD = '0;

    // One complex sample as it sits inside a lane field: re above im.
    typedef struct packed {
        logic [SAMPLE_W-1:0] re;
        logic [SAMPLE_W-1:0] im;
    } sample_t;

    // Bit offset of lane k inside a packed word.
    function automatic int lane_lsb(input int k);
        return k * LANE_BITS;
    endfunction

endpackage : fft_frame_packer_pkg
`default_nettype wire

// File: rtl/fft_frame_packer_outreg.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_packer_outreg
// Description : Two-entry output stage (output register + one pending word)
//               with valid/ready on the output side. A completed word goes
//               straight to the output register when it is empty or draining
//               this cycle, otherwise it parks in the pending slot and input
//               acceptance is halted until the pending word is promoted.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               load_valid        - completed word presented this cycle
//               load_data         - the completed word
//               out_ready         - consumer accepts data_out
//               data_out          - output word (IDLE_WORD when not valid)
//               out_valid         - data_out valid
//               in_ready          - registered, equals !pending
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_packer_outreg
    import fft_frame_packer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_data,
    input  logic              out_ready,
    output logic [WORD_W-1:0] data_out,
    output logic              out_valid,
    output logic              in_ready
);

    logic [WORD_W-1:0] r_out;
    logic              r_out_valid;
    logic [WORD_W-1:0] r_pend;
    logic              r_pend_valid;
    logic              r_in_ready;
    logic              w_out_hs;

    assign w_out_hs = r_out_valid & out_ready;

    // load_valid never arrives while a word is pending because the upstream
    // accept is gated by in_ready, so the pending slot cannot be overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out        <= IDLE_WORD;
            r_out_valid  <= 1'b0;
            r_pend       <= IDLE_WORD;
            r_pend_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (load_valid && (!r_out_valid || w_out_hs)) begin
            r_out        <= load_data;
            r_out_valid  <= 1'b1;
        end else if (load_valid) begin
            r_pend       <= load_data;
            r_pend_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end else if (w_out_hs && r_pend_valid) begin
            // Promotion keeps out_valid high across the handshake.
            r_out        <= r_pend;
            r_pend_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_out_hs) begin
            r_out        <= IDLE_WORD;
            r_out_valid  <= 1'b0;
        end
    end

    assign data_out  = r_out;
    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;

endmodule : fft_frame_packer_outreg
`default_nettype wire

// File: rtl/fft_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_packer
// Description : Packs LANES complex samples into one 136-bit word for the FFT
//               input demux and generates the demux routing flag, which is
//               toggled only between frames of WORDS_PER_FRAME words.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               in_valid/in_ready - sample input handshake
//               in_re, in_im      - sample real/imag parts
//               data_out          - packed word to the demux
//               out_valid/out_ready - word output handshake
//               demux_flag        - 1 routes frame to output 1, 0 to output 2
//               frame_done        - pulse on last-word handshake of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_packer
    import fft_frame_packer_pkg::*;
#(
    parameter int SAMPLE_W        = fft_frame_packer_pkg::SAMPLE_W,
    parameter int LANES           = fft_frame_packer_pkg::LANES,
    parameter int WORDS_PER_FRAME = fft_frame_packer_pkg::WORDS_PER_FRAME
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_re,
    input  logic [SAMPLE_W-1:0] in_im,
    output logic [WORD_W-1:0]   data_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                demux_flag,
    output logic                frame_done
);

    localparam int c_FIELD_W = 2 * SAMPLE_W;
    localparam int c_LANE_CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int c_WORD_CW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam logic [c_LANE_CW-1:0] c_LAST_LANE = c_LANE_CW'(LANES - 1);
    localparam logic [c_WORD_CW-1:0] c_LAST_WORD = c_WORD_CW'(WORDS_PER_FRAME - 1);

    logic [c_FIELD_W-1:0] r_field [LANES-1];
    logic [c_LANE_CW-1:0] r_lane;
    logic [c_WORD_CW-1:0] r_word;
    logic                 r_flag;

    logic                 w_accept;
    logic                 w_last_lane;
    logic                 w_word_load;
    logic                 w_out_hs;
    logic                 w_last_word;
    logic [WORD_W-1:0]    w_word;

    assign w_accept    = in_valid & in_ready;
    assign w_last_lane = (r_lane == c_LAST_LANE);
    assign w_word_load = w_accept & w_last_lane;
    assign w_out_hs    = out_valid & out_ready;
    assign w_last_word = (r_word == c_LAST_WORD);

    // Lanes 0..LANES-2 come from the holding registers; the last lane is the
    // sample being accepted right now, so the word is complete this cycle.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        if (k == LANES - 1) begin : g_live
            assign w_word[lane_lsb(k) +: c_FIELD_W] = {in_re, in_im};
        end else begin : g_held
            assign w_word[lane_lsb(k) +: c_FIELD_W] = r_field[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane <= '0;
            for (int k = 0; k < LANES - 1; k++) begin
                r_field[k] <= '0;
            end
        end else if (w_accept) begin
            r_lane <= w_last_lane ? '0 : r_lane + 1'b1;
            for (int k = 0; k < LANES - 1; k++) begin
                if (r_lane == c_LANE_CW'(k)) begin
                    r_field[k] <= {in_re, in_im};
                end
            end
        end
    end

    // Flag flips only after the final word of a frame has been handed off,
    // so every word of one frame carries the same routing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
            r_flag <= 1'b1;
        end else if (w_out_hs) begin
            if (w_last_word) begin
                r_word <= '0;
                r_flag <= ~r_flag;
            end else begin
                r_word <= r_word + 1'b1;
            end
        end
    end

    fft_frame_packer_outreg u_outreg (
        .clk        (clk),
        .rst        (rst),
        .load_valid (w_word_load),
        .load_data  (w_word),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .in_ready   (in_ready)
    );

    assign demux_flag = r_flag;
    // Masked during reset so a reset never produces a spurious frame end.
    assign frame_done = w_out_hs & w_last_word & ~rst;

endmodule : fft_frame_packer
`default_nettype wire

// File: tb/tb_fft_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_frame_packer
// Description : Directed and randomized-handshake bench for fft_frame_packer
//               with a packing/frame scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [16:0]  in_re;
    logic [16:0]  in_im;
    logic [135:0] data_out;
    logic         out_valid;
    logic         out_ready;
    logic         demux_flag;
    logic         frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int fd_cnt   = 0;
    int flag0_cnt = 0;
    bit rand_rdy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fft_frame_packer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_re      (in_re),
        .in_im      (in_im),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .demux_flag (demux_flag),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard / frame model ----------------
    logic [33:0]  m_buf [4];
    int           m_lane;
    logic [135:0] exp_q [$];
    logic         m_flag;
    int           m_wcnt;
    logic         prev_hold;
    logic [135:0] prev_data;

    always @(negedge clk) begin
        if (rst) begin
            m_lane    = 0;
            exp_q.delete();
            m_flag    = 1'b1;
            m_wcnt    = 0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", data_out, prev_data);
            end
            if (!out_valid) check("idle_zero", data_out, 0);
            if (in_valid && in_ready) begin
                m_buf[m_lane] = {in_re, in_im};
                if (m_lane == 3) begin
                    exp_q.push_back({m_buf[3], m_buf[2], m_buf[1], m_buf[0]});
                    m_lane = 0;
                end else begin
                    m_lane++;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_word", 1, 0);
                else check("word", data_out, exp_q.pop_front());
                check("flag", demux_flag, m_flag);
                check("frame_done", frame_done, (m_wcnt == 3));
                if (frame_done) fd_cnt++;
                if (!demux_flag) flag0_cnt++;
                if (m_wcnt == 3) begin
                    m_wcnt = 0;
                    m_flag = ~m_flag;
                end else begin
                    m_wcnt++;
                end
            end else begin
                check("no_done", frame_done, 0);
            end
            prev_hold = out_valid && !out_ready;
            prev_data = data_out;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 1) != 0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [16:0] re, input logic [16:0] im);
        int n = 0;
        bit done = 1'b0;
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!done && n >= 200) begin
                check("send_timeout", 0, 1);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        idle(2);
        rst      = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            idle(1);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, fd0, f00;
        rst = 1'b1; in_valid = 1'b1; in_re = 17'h0; in_im = 17'h0; out_ready = 1'b0;

        // Reset with in_valid asserted.
        idle(2);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_flag", demux_flag, 1);
        check("rst_frame_done", frame_done, 0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

        // Bit layout.
        send(17'h00001, 17'h1FFFF);
        send(17'h00002, 17'h00000);
        send(17'h0FFFF, 17'h10000);
        check("layout_not_yet", out_valid, 0);
        send(17'h1FFFF, 17'h00003);
        check("layout_valid", out_valid, 1);
        check("layout_lane0", data_out[33:0], {17'h00001, 17'h1FFFF});
        check("layout_lane3", data_out[135:102], {17'h1FFFF, 17'h00003});
        check("layout_lane2", data_out[101:68], {17'h0FFFF, 17'h10000});
        check("layout_flag", demux_flag, 1);

        // Three full frames back to back.
        do_reset();
        fd0 = fd_cnt; f00 = flag0_cnt; t0 = cyc;
        for (int i = 0; i < 48; i++) send(17'(i * 3 + 1), 17'(17'h1FFFF - i));
        check("stream_cycles", cyc - t0, 48);
        idle(3);
        check("stream_frames", fd_cnt - fd0, 3);
        check("stream_flag0_words", flag0_cnt - f00, 4);
        check("stream_flag_end", demux_flag, 0);

        // Backpressure: 10 cycles with out_ready low.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(17'(16'h100 + i), 17'(16'h200 + i));
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        in_valid = 1'b1; in_re = 17'h00ABC; in_im = 17'h1DEF0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_in_blocked", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(17'h00ABC, 17'h1DEF0);
        for (int i = 0; i < 7; i++) send(17'(16'h300 + i), 17'(16'h400 + i));
        drain();

        // Reset after six accepted samples.
        for (int i = 0; i < 6; i++) send(17'(16'h500 + i), 17'(16'h600 + i));
        do_reset();
        check("mid_rst_flag", demux_flag, 1);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        fd0 = fd_cnt; f00 = flag0_cnt;
        for (int i = 0; i < 16; i++) send(17'(16'h700 + i), 17'(16'h7F0 - i));
        idle(3);
        check("mid_rst_frames", fd_cnt - fd0, 1);
        check("mid_rst_flag0", flag0_cnt - f00, 0);

        // Random valid/ready over 64 frames.
        do_reset();
        fd0 = fd_cnt;
        rand_rdy = 1'b1;
        for (int i = 0; i < 64 * 16; i++) begin
            idle($urandom_range(0, 2));
            send(17'($urandom), 17'($urandom));
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        drain();
        check("rand_frames", fd_cnt - fd0, 64);
        check("rand_flag_end", demux_flag, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fft_frame_packer
`default_nettype wire
